// File: rtl/adder_tree_acc_if.sv
`default_nettype none
// ============================================================================
//  Module   : adder_tree_acc_if
//  Brief    : Beat-in / frame-result-out bundle for the adder tree accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
interface adder_tree_acc_if #(
    parameter int WL = 40,
    parameter int N  = 16,
    parameter int OW = WL + $clog2(N) + 8,
    parameter int CW = 8
);
    logic              i_valid;
    logic              i_last;
    logic [N*WL-1:0]   i_data;
    logic              o_valid;
    logic [OW-1:0]     o_sum;
    logic [CW-1:0]     o_beats;
    logic              o_ovf;

    modport master (
        output i_valid,
        output i_last,
        output i_data,
        input  o_valid,
        input  o_sum,
        input  o_beats,
        input  o_ovf
    );

    modport slave (
        input  i_valid,
        input  i_last,
        input  i_data,
        output o_valid,
        output o_sum,
        output o_beats,
        output o_ovf
    );
endinterface
`default_nettype wire

// File: rtl/adder_tree_acc.sv
`default_nettype none
// ============================================================================
//  Module   : adder_tree_acc
//  Brief    : Pipelined signed adder tree with saturating frame accumulation.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_tree_acc #(
    parameter int WL    = 40,
    parameter int N     = 16,
    parameter int LOG2N = $clog2(N),
    parameter int AW    = 8,
    parameter int CW    = 8,
    parameter int OW    = WL + LOG2N + AW
) (
    input  wire                  clk,
    input  wire                  reset,
    adder_tree_acc_if.slave      bus
);

    // Bit offset of tree stage s inside the flattened tap bus.
    function automatic int f_off(input int s);
        int o;
        o = 0;
        for (int i = 0; i < s; i++) begin
            o += (N >> i) * (WL + i);
        end
        return o;
    endfunction

    localparam int TW        = WL + LOG2N;
    localparam int TAP_W     = f_off(LOG2N + 1);
    localparam logic [OW-1:0] c_sum_max = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] c_sum_min = {1'b1, {(OW-1){1'b0}}};
    localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};

    wire [TAP_W-1:0]     w_tap;
    logic [LOG2N-1:0]    r_vld;
    logic [LOG2N-1:0]    r_lst;

    assign w_tap[0 +: N*WL] = bus.i_data;

    generate
        for (genvar s = 1; s <= LOG2N; s++) begin : g_stage
            localparam int SW = WL + s;
            localparam int NS = N >> s;
            localparam int OI = f_off(s - 1);
            localparam int OO = f_off(s);

            wire  [NS*SW-1:0] w_nxt;
            logic [NS*SW-1:0] r_sum;

            for (genvar j = 0; j < NS; j++) begin : g_pair
                wire [SW-2:0] w_a = w_tap[OI + (2*j)   * (SW-1) +: SW-1];
                wire [SW-2:0] w_b = w_tap[OI + (2*j+1) * (SW-1) +: SW-1];
                assign w_nxt[j*SW +: SW] = {w_a[SW-2], w_a} + {w_b[SW-2], w_b};
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sum <= '0;
                end else begin
                    r_sum <= w_nxt;
                end
            end

            assign w_tap[OO +: NS*SW] = r_sum;
        end
    endgenerate

    // Valid/last ride alongside the tree; last is only meaningful with valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            r_lst <= '0;
        end else begin
            r_vld[0] <= bus.i_valid;
            r_lst[0] <= bus.i_valid & bus.i_last;
            for (int i = 1; i < LOG2N; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_lst[i] <= r_lst[i-1];
            end
        end
    end

    wire [TW-1:0] w_tree   = w_tap[f_off(LOG2N) +: TW];
    wire          w_t_vld  = r_vld[LOG2N-1];
    wire          w_t_last = r_lst[LOG2N-1];

    logic [OW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_open;
    logic          r_o_valid;
    logic [OW-1:0] r_o_sum;
    logic [CW-1:0] r_o_beats;
    logic          r_o_ovf;

    logic [OW-1:0] w_t;
    logic [OW-1:0] w_base;
    logic [OW:0]   w_add;
    logic          w_sat;
    logic [OW-1:0] w_acc_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_ovf_next;

    // One extra sum bit exposes overflow; the two top bits disagree on wrap.
    always_comb begin
        w_t        = OW'($signed(w_tree));
        w_base     = r_open ? r_acc : '0;
        w_add      = {w_base[OW-1], w_base} + {w_t[OW-1], w_t};
        w_sat      = w_add[OW] ^ w_add[OW-1];
        w_acc_next = w_add[OW-1:0];
        if (w_sat) begin
            w_acc_next = w_add[OW] ? c_sum_min : c_sum_max;
        end
        w_cnt_next = CW'(1);
        if (r_open) begin
            w_cnt_next = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CW'(1);
        end
        w_ovf_next = (r_open & r_ovf) | w_sat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_open    <= 1'b0;
            r_o_valid <= 1'b0;
            r_o_sum   <= '0;
            r_o_beats <= '0;
            r_o_ovf   <= 1'b0;
        end else begin
            r_o_valid <= 1'b0;
            if (w_t_vld) begin
                if (w_t_last) begin
                    r_o_sum   <= w_acc_next;
                    r_o_beats <= w_cnt_next;
                    r_o_ovf   <= w_ovf_next;
                    r_o_valid <= 1'b1;
                    r_open    <= 1'b0;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_ovf     <= 1'b0;
                end else begin
                    r_acc     <= w_acc_next;
                    r_cnt     <= w_cnt_next;
                    r_ovf     <= w_ovf_next;
                    r_open    <= 1'b1;
                end
            end
        end
    end

    assign bus.o_valid = r_o_valid;
    assign bus.o_sum   = r_o_sum;
    assign bus.o_beats = r_o_beats;
    assign bus.o_ovf   = r_o_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_tree_acc
//  Brief    : Bench for adder_tree_acc: wide-guard and zero-guard/2-bit-count DUTs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_tree_acc;
    localparam int WL    = 40;
    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int OWM   = 52;
    localparam int OWS   = 44;
    localparam int CWM   = 8;
    localparam int CWS   = 2;
    localparam longint MAXL = 64'sd549755813887;
    localparam longint MINL = -64'sd549755813888;

    typedef struct {
        int     mode;
        longint val;
        bit     v;
        bit     l;
        longint sm; int bm; bit om;
        longint ss; int bs; bit os;
    } vec_t;

    typedef struct {
        int     cyc;
        longint sum;
        int     beats;
        bit     ovf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            drv_valid = 1'b0;
    logic            drv_last  = 1'b0;
    logic [N*WL-1:0] drv_data  = '0;
    always #5 clk = ~clk;

    adder_tree_acc_if #(.WL(WL), .N(N), .OW(OWM), .CW(CWM)) if_m ();
    adder_tree_acc_if #(.WL(WL), .N(N), .OW(OWS), .CW(CWS)) if_s ();

    assign if_m.i_valid = drv_valid;
    assign if_m.i_last  = drv_last;
    assign if_m.i_data  = drv_data;
    assign if_s.i_valid = drv_valid;
    assign if_s.i_last  = drv_last;
    assign if_s.i_data  = drv_data;

    adder_tree_acc #(.WL(WL), .N(N), .AW(8), .CW(CWM)) u_main (
        .clk(clk), .reset(rst), .bus(if_m.slave));
    adder_tree_acc #(.WL(WL), .N(N), .AW(0), .CW(CWS)) u_sat (
        .clk(clk), .reset(rst), .bus(if_s.slave));

    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;
    longint lanes [N];
    exp_t   q0 [$];
    exp_t   q1 [$];
    longint m_acc [2];
    int     m_cnt [2];
    bit     m_ovf [2];
    bit     m_open[2];
    longint h_sum [2];
    int     h_beats[2];
    bit     h_ovf [2];
    int     owv [2] = '{OWM, OWS};
    int     cwv [2] = '{CWM, CWS};
    vec_t   tab [18];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0; m_cnt[d] = 0; m_ovf[d] = 0; m_open[d] = 0;
            h_sum[d] = 0; h_beats[d] = 0; h_ovf[d] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Frame arithmetic straight from the rules: running sum, clamp, count.
    task automatic model_beat(input int d, input longint t, input bit last,
                              input bit use_tab, input longint ts, input int tbt, input bit tov);
        longint maxv, minv, s;
        int     c, cmax;
        bit     o;
        exp_t   e;
        maxv = (longint'(1) <<< (owv[d] - 1)) - 1;
        minv = -maxv - 1;
        cmax = (1 << cwv[d]) - 1;
        s = m_open[d] ? m_acc[d] + t : t;
        o = 0;
        if (s > maxv) begin s = maxv; o = 1; end
        if (s < minv) begin s = minv; o = 1; end
        c = m_open[d] ? ((m_cnt[d] >= cmax) ? cmax : m_cnt[d] + 1) : 1;
        o = o | (m_open[d] & m_ovf[d]);
        if (last) begin
            e.cyc   = cyc + LOG2N + 1;
            e.sum   = use_tab ? ts  : s;
            e.beats = use_tab ? tbt : c;
            e.ovf   = use_tab ? tov : o;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            m_open[d] = 0; m_acc[d] = 0; m_cnt[d] = 0; m_ovf[d] = 0;
        end else begin
            m_open[d] = 1; m_acc[d] = s; m_cnt[d] = c; m_ovf[d] = o;
        end
    endtask

    task automatic drive(input bit v, input bit l, input bit use_tab,
                         input longint sm, input int bm, input bit om,
                         input longint ss, input int bs, input bit os);
        longint t;
        @(posedge clk);
        #1;
        drv_valid = v;
        drv_last  = l;
        t = 0;
        for (int k = 0; k < N; k++) begin
            drv_data[k*WL +: WL] = lanes[k][WL-1:0];
            t += lanes[k];
        end
        if (v) begin
            model_beat(0, t, l, use_tab, sm, bm, om);
            model_beat(1, t, l, use_tab, ss, bs, os);
        end
    endtask

    task automatic idle(input bit l);
        drive(1'b0, l, 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic mon(input int d, input bit v, input longint s, input int b, input bit o);
        exp_t  e;
        bit    due;
        string nm;
        nm  = (d == 0) ? "main" : "sat";
        due = 0;
        if (d == 0) begin
            if (q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); due = 1; end
        end else begin
            if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); due = 1; end
        end
        if (due) begin
            chk({nm, " o_valid pulse"}, v, 1);
            chk({nm, " o_sum"},   s, e.sum);
            chk({nm, " o_beats"}, b, e.beats);
            chk({nm, " o_ovf"},   o, e.ovf);
            h_sum[d] = e.sum; h_beats[d] = e.beats; h_ovf[d] = e.ovf;
        end else begin
            chk({nm, " o_valid idle"}, v, 0);
            chk({nm, " o_sum hold"},   s, h_sum[d]);
            chk({nm, " o_beats hold"}, b, h_beats[d]);
            chk({nm, " o_ovf hold"},   o, h_ovf[d]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, if_m.o_valid, longint'($signed(if_m.o_sum)), int'(if_m.o_beats), if_m.o_ovf);
            mon(1, if_s.o_valid, longint'($signed(if_s.o_sum)), int'(if_s.o_beats), if_s.o_ovf);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, " main o_valid"}, if_m.o_valid, 0);
        chk({tag, " main o_sum"},   longint'($signed(if_m.o_sum)), 0);
        chk({tag, " main o_beats"}, if_m.o_beats, 0);
        chk({tag, " main o_ovf"},   if_m.o_ovf, 0);
        chk({tag, " sat o_valid"},  if_s.o_valid, 0);
        chk({tag, " sat o_sum"},    longint'($signed(if_s.o_sum)), 0);
        chk({tag, " sat o_beats"},  if_s.o_beats, 0);
        chk({tag, " sat o_ovf"},    if_s.o_ovf, 0);
    endtask

    function automatic longint rnd_lane();
        int     r;
        longint x;
        r = $urandom_range(0, 7);
        if (r == 0) return MAXL;
        if (r == 1) return MINL;
        x = {$urandom(), $urandom()};
        x = (x <<< 24) >>> 24;
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //           mode val    v  l   main sum/beats/ovf          sat sum/beats/ovf
        tab[0]  = '{1, 0,     1, 1, 136, 1, 0,                 136, 1, 0};
        tab[1]  = '{0, -1,    1, 0, 0, 0, 0,                   0, 0, 0};
        tab[2]  = '{0, -1,    1, 0, 0, 0, 0,                   0, 0, 0};
        tab[3]  = '{0, 0,     0, 0, 0, 0, 0,                   0, 0, 0};
        tab[4]  = '{0, -1,    1, 0, 0, 0, 0,                   0, 0, 0};
        tab[5]  = '{0, -1,    1, 1, -64, 4, 0,                 -64, 3, 0};
        tab[6]  = '{0, 2,     1, 1, 32, 1, 0,                  32, 1, 0};
        tab[7]  = '{0, 3,     1, 1, 48, 1, 0,                  48, 1, 0};
        tab[8]  = '{0, 5,     0, 1, 0, 0, 0,                   0, 0, 0};
        tab[9]  = '{0, 1,     1, 1, 16, 1, 0,                  16, 1, 0};
        tab[10] = '{0, MAXL,  1, 0, 0, 0, 0,                   0, 0, 0};
        tab[11] = '{0, MAXL,  1, 1, 64'sd17592186044384, 2, 0, 64'sd8796093022207, 2, 1};
        tab[12] = '{0, 0,     1, 1, 0, 1, 0,                   0, 1, 0};
        tab[13] = '{0, 0,     1, 0, 0, 0, 0,                   0, 0, 0};
        tab[14] = '{0, 0,     1, 0, 0, 0, 0,                   0, 0, 0};
        tab[15] = '{0, 0,     1, 0, 0, 0, 0,                   0, 0, 0};
        tab[16] = '{0, 0,     1, 0, 0, 0, 0,                   0, 0, 0};
        tab[17] = '{0, 0,     1, 1, 0, 5, 0,                   0, 3, 0};

        for (int k = 0; k < N; k++) lanes[k] = 0;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        #2 rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            for (int k = 0; k < N; k++) lanes[k] = (tab[i].mode == 1) ? longint'(k + 1) : tab[i].val;
            drive(tab[i].v, tab[i].l, 1'b1, tab[i].sm, tab[i].bm, tab[i].om,
                  tab[i].ss, tab[i].bs, tab[i].os);
        end
        repeat (LOG2N + 3) idle(1'b0);

        // Reset mid-frame with a closing beat still inside the tree.
        for (int k = 0; k < N; k++) lanes[k] = 7;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 drv_valid = 1'b0; drv_last = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 chk_zero("mid-frame reset");
        repeat (2) @(posedge clk);
        #1 chk_zero("reset held");
        #2 rst = 1'b0;
        for (int k = 0; k < N; k++) lanes[k] = 1;
        drive(1, 1, 1, 16, 1, 0, 16, 1, 0);
        repeat (LOG2N + 3) idle(1'b0);

        for (int f = 0; f < 60; f++) begin
            int nb;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < N; k++) lanes[k] = rnd_lane();
                drive(1, (b == nb - 1), 0, 0, 0, 0, 0, 0, 0);
                if (b < nb - 1 && $urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 1)));
        end
        repeat (LOG2N + 4) idle(1'b0);
        @(posedge clk);
        #1;
        chk("main pending results", q0.size(), 0);
        chk("sat pending results",  q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adder_tree_acc.md
Name: adder_tree_acc

Overview:
- Parametrised, pipelined signed adder tree that reduces N fixed-point lanes per beat to one sum.
- Optionally accumulates successive beats into a frame total, delimited by i_last.
- Sits after the multiplier array in the MAC datapath. Dot products longer than N are streamed as multiple beats, and one frame result is emitted per i_last.
- Adds valid tracking, frame accumulation, saturation and a beat count.

Parameters:
- WL, 40, input lane word length in bits (2*(IL+FL) of the product format).
- N, 16, number of input lanes; must be a power of two, 2 to 64.
- LOG2N, $clog2(N), tree depth; derived, do not override.
- AW, 8, accumulator guard bits above tree output width.
- CW, 8, beat-counter width.
- OW, WL+LOG2N+AW, output sum width; derived.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  beat valid.
- i_last  input  1  last beat of frame; qualified by i_valid.
- i_data  input  N*WL  signed lanes, lane k at bits [k*WL +: WL].
- o_valid  output  1  one-cycle pulse, frame result valid.
- o_sum  output  OW  signed frame sum (saturated).
- o_beats  output  CW  number of valid beats in frame (saturates at 2^CW-1).
- o_ovf  output  1  frame saturated at least once.

Behaviour:
- Reset (async, active-high) clears all pipeline registers, valid/last shift bits, accumulator, counters and flags.
- Reset values: o_valid=0, o_sum=0, o_beats=0, o_ovf=0.
- Tree:
  - LOG2N registered stages.
  - Stage s (1..LOG2N) holds N/2^s pairwise sums of width WL+s.
  - Each sum is the sign-extended addition of adjacent pairs from stage s-1, in lane order (lane 2j + lane 2j+1).
  - No overflow is possible inside the tree.
- Valid and last travel in a LOG2N-deep shift register alongside the data.
- Data registers may load every cycle. Invalid beats must not affect the accumulator, count or outputs.
- Accumulator stage, acting on tree output T (sign-extended to OW) when its valid bit is set:
  - Frame open: acc_next = acc + T. Frame not open (first beat): acc_next = T.
  - If acc + T exceeds the OW signed range, acc_next clamps to +max/-min and ovf_frame is set.
  - beat count: 1 on the first beat, else +1, saturating at 2^CW-1.
  - last=0: store acc_next and count; frame remains open.
  - last=1: register o_sum=acc_next, o_beats=count, o_ovf=ovf_frame; pulse o_valid for one cycle; close frame and clear ovf_frame and count.
- Latency: beat with i_valid=i_last=1 at cycle t gives o_valid at t+LOG2N+1.
- Throughput: one beat per cycle, no backpressure. Gaps (i_valid=0) between beats of a frame are allowed and leave state unchanged.
- Single-beat frame (first beat also last): output equals that beat's tree sum; o_beats=1.
- o_sum, o_beats and o_ovf hold their value between o_valid pulses.
- i_last with i_valid=0 is ignored.
- Reset mid-frame discards the partial frame and any in-flight beats; no o_valid is produced for them.
- Back-to-back frames (last at cycle t, new first beat at t+1) must not leak accumulator state between frames.

Test Plan:
- N=16, WL=40. Single beat, lanes k=0..15 set to value k+1, i_last=1 → o_valid exactly 5 cycles later, o_sum=136, o_beats=1, o_ovf=0.
- Four beats, all lanes -1, last on beat 4, one idle cycle inserted between beats 2 and 3 → single o_valid pulse, o_sum=-64, o_beats=4, no pulse before beat 4 completes.
- Back-to-back frames: frame A one beat with all lanes 2 (last); frame B next cycle, one beat with all lanes 3 (last) → two consecutive o_valid pulses, sums 32 then 48.
- Saturation: AW=0, all lanes +max (2^39-1), two beats → o_sum=2^43-1, o_ovf=1; next frame of all zeros → o_sum=0, o_ovf=0.
- Reset asserted asynchronously mid-frame after 2 beats, then released; then one beat all lanes 1, last → o_sum=16, o_beats=1; outputs 0 while reset is asserted.
- Beat-count saturation: CW=2, 5-beat frame of all zeros → o_beats=3.
